fxp_divider: RTL and testbench

FXP_DIVIDER -- requirements
Module: fxp_divider

---
 rtl/fxp_divider.sv | 212 +++++++++++++++++++++
 tb/tb_fxp_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fxp_divider.sv
// Fixed-point signed divider: (a * 2^FRAC) / b with truncation toward zero
// and saturation to a Q_W-bit signed result. The divisor is an unsigned
// magnitude. Radix-2 restoring division produces one quotient bit per
// enabled cycle, MSB first; the sign is applied once the magnitude is complete.
module fxp_divider #(
   parameter int A_W  = 27,
   parameter int B_W  = 27,
   parameter int FRAC = 14,
   parameter int Q_W  = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [A_W-1:0] i_a,
   input  logic [B_W-1:0] i_b,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [Q_W-1:0] o_q,
   output logic           o_ovf,
   output logic           o_dz
);

   localparam int N_ITER = A_W - 1 + FRAC;
   localparam int CNT_W  = ($clog2(N_ITER) > 6) ? $clog2(N_ITER) : 6;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

   // Largest magnitudes representable for a positive / negative result.
   localparam logic [N_ITER:0] MAG_LIM_POS = {{(N_ITER+2-Q_W){1'b0}}, {(Q_W-1){1'b1}}};
   localparam logic [N_ITER:0] MAG_LIM_NEG = {{(N_ITER+1-Q_W){1'b0}}, 1'b1, {(Q_W-1){1'b0}}};
   localparam logic [Q_W-1:0]  Q_MAX       = {1'b0, {(Q_W-1){1'b1}}};
   localparam logic [Q_W-1:0]  Q_MIN       = {1'b1, {(Q_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Apply sign and saturate a full quotient magnitude; returns {ovf, q}.
   function automatic logic [Q_W:0] saturate(input logic [N_ITER:0] mag, input logic neg);
      logic [N_ITER:0] lim;
      logic [Q_W-1:0]  q;
      logic            ovf;
      lim = neg ? MAG_LIM_NEG : MAG_LIM_POS;
      ovf = (mag > lim);
      if (ovf) begin
         q = neg ? Q_MIN : Q_MAX;
      end else if (neg) begin
         q = -mag[Q_W-1:0];
      end else begin
         q = mag[Q_W-1:0];
      end
      return {ovf, q};
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d;
   logic [B_W-1:0]    b_q, b_d;
   logic [B_W-1:0]    rem_q, rem_d;
   logic [N_ITER-1:0] dvd_q, dvd_d;
   logic [N_ITER-2:0] quo_q, quo_d;
   logic              qtop_q, qtop_d;
   logic              o_valid_q, o_valid_d;
   logic              o_ready_q, o_ready_d;
   logic [Q_W-1:0]    o_q_q, o_q_d;
   logic              o_ovf_q, o_ovf_d;
   logic              o_dz_q, o_dz_d;

   logic [A_W-1:0]    mag_in_s;
   logic              b_zero_s;
   logic              b_one_s;
   logic              top_in_s;
   logic [B_W:0]      trial_s;
   logic [B_W-1:0]    diff_s;
   logic              qbit_s;
   logic [B_W-1:0]    rem_nxt_s;
   logic [N_ITER:0]   q_full_s;
   logic [Q_W:0]      sat_s;

   // Next-state, datapath iteration and output computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      b_d       = b_q;
      rem_d     = rem_q;
      dvd_d     = dvd_q;
      quo_d     = quo_q;
      qtop_d    = qtop_q;
      o_valid_d = o_valid_q;
      o_ready_d = o_ready_q;
      o_q_d     = o_q_q;
      o_ovf_d   = o_ovf_q;
      o_dz_d    = o_dz_q;

      // Operand conditioning for an incoming request. The most negative
      // dividend has a magnitude one bit wider than the iteration window,
      // so that bit pre-loads the remainder (or directly yields the extra
      // top quotient bit when the divisor is 1).
      mag_in_s = i_a[A_W-1] ? -i_a : i_a;
      b_zero_s = (i_b == {B_W{1'b0}});
      b_one_s  = (i_b == {{(B_W-1){1'b0}}, 1'b1});
      top_in_s = mag_in_s[A_W-1];

      // One restoring-division step on the held state.
      trial_s   = {rem_q, dvd_q[N_ITER-1]};
      diff_s    = trial_s[B_W-1:0] - b_q;
      qbit_s    = (trial_s >= {1'b0, b_q});
      rem_nxt_s = qbit_s ? diff_s : trial_s[B_W-1:0];
      q_full_s  = {qtop_q, quo_q, qbit_s};
      sat_s     = saturate(q_full_s, neg_q);

      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               o_ready_d = 1'b0;
               neg_d     = i_a[A_W-1];
               if (b_zero_s) begin
                  state_d   = ST_DONE;
                  o_valid_d = 1'b1;
                  o_dz_d    = 1'b1;
                  o_ovf_d   = 1'b0;
                  o_q_d     = i_a[A_W-1] ? Q_MIN : Q_MAX;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = {CNT_W{1'b0}};
                  b_d     = i_b;
                  dvd_d   = {mag_in_s[A_W-2:0], {FRAC{1'b0}}};
                  quo_d   = {(N_ITER-1){1'b0}};
                  qtop_d  = top_in_s & b_one_s;
                  rem_d   = {{(B_W-1){1'b0}}, top_in_s & ~b_one_s};
               end
            end else begin
               o_ready_d = 1'b1;
            end
         end
         ST_BUSY: begin
            rem_d = rem_nxt_s;
            dvd_d = {dvd_q[N_ITER-2:0], 1'b0};
            quo_d = {quo_q[N_ITER-3:0], qbit_s};
            if (cnt_q == CNT_LAST) begin
               state_d   = ST_DONE;
               o_valid_d = 1'b1;
               o_dz_d    = 1'b0;
               o_ovf_d   = sat_s[Q_W];
               o_q_d     = sat_s[Q_W-1:0];
            end else begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            // Consuming the result only returns to IDLE; a request present
            // on this same edge is seen no earlier than the next one.
            if (i_ready) begin
               state_d   = ST_IDLE;
               o_valid_d = 1'b0;
               o_ready_d = 1'b1;
            end else begin
               o_valid_d = 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            o_valid_d = 1'b0;
            o_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers: synchronous reset, global stall on i_en.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         neg_q     <= 1'b0;
         b_q       <= {B_W{1'b0}};
         rem_q     <= {B_W{1'b0}};
         dvd_q     <= {N_ITER{1'b0}};
         quo_q     <= {(N_ITER-1){1'b0}};
         qtop_q    <= 1'b0;
         o_valid_q <= 1'b0;
         o_ready_q <= 1'b1;
         o_q_q     <= {Q_W{1'b0}};
         o_ovf_q   <= 1'b0;
         o_dz_q    <= 1'b0;
      end else if (i_en) begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         b_q       <= b_d;
         rem_q     <= rem_d;
         dvd_q     <= dvd_d;
         quo_q     <= quo_d;
         qtop_q    <= qtop_d;
         o_valid_q <= o_valid_d;
         o_ready_q <= o_ready_d;
         o_q_q     <= o_q_d;
         o_ovf_q   <= o_ovf_d;
         o_dz_q    <= o_dz_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_ready = o_ready_q;
   assign o_q     = o_q_q;
   assign o_ovf   = o_ovf_q;
   assign o_dz    = o_dz_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Self-checking bench for fxp_divider: expected results are computed from a
// 64-bit integer model, queued when a request is driven and compared when
// the divider presents its result.
module tb_fxp_divider;

   localparam int A_W    = 27;
   localparam int B_W    = 27;
   localparam int FRAC   = 14;
   localparam int Q_W    = 16;
   localparam int N_ITER = A_W - 1 + FRAC;
   localparam int NO_RST = -1;

   typedef struct {
      logic [Q_W-1:0] q;
      logic           ovf;
      logic           dz;
      int             lat;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic           valid_in;
   logic           ready_out;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic           valid_out;
   logic           ready_in;
   logic [Q_W-1:0] q;
   logic           ovf;
   logic           dz;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   fxp_divider #(.A_W(A_W), .B_W(B_W), .FRAC(FRAC), .Q_W(Q_W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (en),
      .i_valid (valid_in),
      .o_ready (ready_out),
      .i_a     (a),
      .i_b     (b),
      .o_valid (valid_out),
      .i_ready (ready_in),
      .o_q     (q),
      .o_ovf   (ovf),
      .o_dz    (dz)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Safety net against a hung run.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: exact integer division with C-style truncation, then saturate.
   function automatic exp_t model(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input int extra);
      exp_t   e;
      longint num;
      longint den;
      longint qq;
      longint lo;
      longint hi;
      lo = -(64'sd1 <<< (Q_W - 1));
      hi = (64'sd1 <<< (Q_W - 1)) - 64'sd1;
      if (bv == {B_W{1'b0}}) begin
         e.dz  = 1'b1;
         e.ovf = 1'b0;
         e.q   = av[A_W-1] ? Q_W'(lo) : Q_W'(hi);
         e.lat = 1;
      end else begin
         num = longint'($signed(av)) * (64'sd1 <<< FRAC);
         den = longint'(bv);
         qq  = num / den;
         e.dz  = 1'b0;
         e.ovf = (qq > hi) || (qq < lo);
         if (qq > hi) e.q = Q_W'(hi);
         else if (qq < lo) e.q = Q_W'(lo);
         else e.q = Q_W'(qq);
         e.lat = N_ITER + 1 + extra;
      end
      return e;
   endfunction

   // Drive one request and check its result. Optional: stall i_en for
   // stall_len cycles starting at latency count stall_at, assert reset at
   // latency count rst_at, or hold i_ready low for 'hold' cycles in DONE.
   task automatic run_req(input logic [A_W-1:0] av, input logic [B_W-1:0] bv,
                          input int stall_at, input int stall_len,
                          input int rst_at, input int hold);
      exp_t           e;
      int             lat;
      chk("ready_idle", ready_out, 1'b1);
      sb_q.push_back(model(av, bv, stall_len));
      a        = av;
      b        = bv;
      valid_in = 1'b1;
      ready_in = (hold == 0);
      tick();
      valid_in = 1'b0;
      a        = ~av;
      b        = ~bv;
      lat      = 1;
      while (!valid_out && lat < 200) begin
         if (lat == rst_at) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            e = sb_q.pop_front();
            chk("abort_valid", valid_out, 1'b0);
            chk("abort_ready", ready_out, 1'b1);
            chk("abort_q", q, {Q_W{1'b0}});
            return;
         end
         en = !(lat >= stall_at && lat < stall_at + stall_len);
         tick();
         lat++;
      end
      en = 1'b1;
      e = sb_q.pop_front();
      chk("latency", lat, e.lat);
      chk("q", q, e.q);
      chk("ovf", ovf, e.ovf);
      chk("dz", dz, e.dz);
      chk("ready_in_done", ready_out, 1'b0);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            valid_in = ~valid_in;
            a        = A_W'($urandom);
            tick();
            chk("hold_valid", valid_out, 1'b1);
            chk("hold_q", q, e.q);
            chk("hold_ovf", ovf, e.ovf);
            chk("hold_ready", ready_out, 1'b0);
         end
         valid_in = 1'b1;
         a        = av;
         b        = bv;
         ready_in = 1'b1;
         tick();
         valid_in = 1'b0;
         chk("no_accept_on_consume", ready_out, 1'b1);
         chk("consumed_hold", valid_out, 1'b0);
      end else begin
         tick();
         chk("consumed", valid_out, 1'b0);
      end
   endtask

   initial begin
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      rst      = 1'b1;
      en       = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      a        = {A_W{1'b0}};
      b        = {B_W{1'b0}};
      tick();
      tick();
      chk("rst_valid", valid_out, 1'b0);
      chk("rst_ready", ready_out, 1'b1);
      chk("rst_q", q, {Q_W{1'b0}});
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_dz", dz, 1'b0);
      rst = 1'b0;
      en  = 1'b1;
      tick();

      run_req(A_W'(16384),    B_W'(32768), 0, 0, NO_RST, 0);
      run_req(A_W'(-1),       B_W'(3),     0, 0, NO_RST, 0);
      run_req(A_W'(-16384),   B_W'(32768), 0, 0, NO_RST, 0);
      run_req(A_W'(1 << 20),  B_W'(1),     0, 0, NO_RST, 0);
      run_req(A_W'(-(1 << 20)), B_W'(1),   0, 0, NO_RST, 0);
      run_req(A_W'(-5),       B_W'(0),     0, 0, NO_RST, 0);
      run_req(A_W'(5),        B_W'(0),     0, 0, NO_RST, 0);
      run_req(A_W'(0),        B_W'(7),     0, 0, NO_RST, 0);
      run_req(A_W'(-(1 << 26)), B_W'((1 << 27) - 1), 0, 0, NO_RST, 0);
      run_req(A_W'(-(1 << 26)), B_W'(1),   0, 0, NO_RST, 0);
      run_req(A_W'((1 << 26) - 1), B_W'((1 << 27) - 1), 0, 0, NO_RST, 0);
      run_req(A_W'(-32768),   B_W'(16384), 0, 0, NO_RST, 0);
      run_req(A_W'(32768),    B_W'(16384), 0, 0, NO_RST, 0);
      run_req(A_W'(1000),     B_W'(7),     0, 0, NO_RST, 5);
      run_req(A_W'(16384),    B_W'(32768), 10, 3, NO_RST, 0);
      run_req(A_W'(16384),    B_W'(32768), 0, 0, 20, 0);
      run_req(A_W'(16384),    B_W'(32768), 0, 0, NO_RST, 0);

      for (int k = 0; k < 12; k++) begin
         ra = A_W'($urandom);
         rb = B_W'($urandom) >> $urandom_range(0, 26);
         run_req(ra, rb, 0, 0, NO_RST, 0);
      end

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
